// File: rtl/softmax_frame_scheduler.sv
// softmax_frame_scheduler: shares one softmax pipeline between two requesters.
// A round-robin grant picks a requester. Its frame of number_of_data elements
// is streamed into the pipeline, and exactly number_of_data results are
// collected and returned tagged with the owner id. A watchdog limits the time
// spent waiting for results.
module softmax_frame_scheduler #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int timeout_cycles = 1024
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 req0_valid_i,
  input  logic [data_size-1:0] req0_data_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [data_size-1:0] req1_data_i,
  output logic                 req1_ready_o,
  output logic                 sm_start_o,
  output logic [data_size-1:0] sm_data_o,
  input  logic [data_size-1:0] sm_result_i,
  input  logic                 sm_result_valid_i,
  output logic [data_size-1:0] res_data_o,
  output logic                 res_valid_o,
  output logic                 res_id_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 err_o
);

  localparam int cnt_w = $clog2(number_of_data + 1);
  localparam int wd_w  = $clog2(timeout_cycles + 1);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(number_of_data - 1);
  localparam logic [cnt_w-1:0] frame_len = cnt_w'(number_of_data);
  localparam logic [wd_w-1:0]  wd_last   = wd_w'(timeout_cycles - 1);

  typedef enum logic [1:0] {IDLE, START, FEED, DRAIN} state_t;

  state_t               state;
  state_t               state_next;
  logic                 grant;
  logic                 last_grant;
  logic [cnt_w-1:0]     feed_cnt;
  logic [cnt_w-1:0]     res_cnt;
  logic [wd_w-1:0]      wd_cnt;

  logic                 feeding;
  logic                 launch;
  logic                 pick_id;
  logic                 granted_valid;
  logic [data_size-1:0] granted_data;
  logic                 res_take;
  logic                 res_all;
  logic                 wd_expire;

  // A tie goes to the requester that was not served last.
  assign feeding       = (state == START) || (state == FEED);
  assign launch        = (state == IDLE) && (req0_valid_i || req1_valid_i);
  assign pick_id       = (req0_valid_i && req1_valid_i) ? ~last_grant : req1_valid_i;
  assign granted_valid = grant ? req1_valid_i : req0_valid_i;
  assign granted_data  = grant ? req1_data_i : req0_data_i;

  // Results count in every active state. The final result may arrive in the
  // same DRAIN cycle that checks for completion, so it is included here.
  assign res_take  = (state != IDLE) && sm_result_valid_i && (res_cnt != frame_len);
  assign res_all   = (res_cnt == frame_len) || (res_take && (res_cnt == last_beat));
  assign wd_expire = (wd_cnt == wd_last);

  assign req0_ready_o = feeding && !grant;
  assign req1_ready_o = feeding && grant;
  assign busy_o       = (state != IDLE);

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode. A final result in the watchdog's last cycle counts as completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = START;
      START:   state_next = FEED;
      FEED:    if (feed_cnt == last_beat) state_next = DRAIN;
      DRAIN:   if (res_all || wd_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, counters and registered pipeline/result/status outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      feed_cnt     <= '0;
      res_cnt      <= '0;
      wd_cnt       <= '0;
      sm_start_o   <= 1'b0;
      sm_data_o    <= '0;
      res_data_o   <= '0;
      res_valid_o  <= 1'b0;
      res_id_o     <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      sm_start_o   <= launch;
      sm_data_o    <= (feeding && granted_valid) ? granted_data : '0;
      err_o        <= (feeding && !granted_valid) ||
                      ((state == DRAIN) && !res_all && wd_expire);
      frame_done_o <= (state == DRAIN) && res_all;
      res_valid_o  <= res_take;
      if (res_take) begin
        res_data_o <= sm_result_i;
        res_cnt    <= res_cnt + 1'b1;
      end
      if (launch) begin
        grant    <= pick_id;
        res_id_o <= pick_id;
        feed_cnt <= '0;
        res_cnt  <= '0;
        wd_cnt   <= '0;
      end
      if (state == START) feed_cnt <= cnt_w'(1);
      if (state == FEED)  feed_cnt <= feed_cnt + 1'b1;
      if (state == DRAIN) begin
        if (res_all || wd_expire) last_grant <= grant;
        else                      wd_cnt     <= wd_cnt + 1'b1;
      end
    end
  end

endmodule
